// File: rtl/bus_register_file.sv
`default_nettype none
// ============================================================================
// Module   : bus_register_file
// Purpose  : NUM_REGS x DATA_W register file behind one bidirectional bus
//            port. It has an optional hardwired-zero register 0, a sticky
//            out-of-range address flag, and a self-sequenced bulk clear.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock    in     rising-edge system clock
//   reset    in     asynchronous, active-low reset
//   addr     in     register select (>= NUM_REGS is out of range)
//   data     inout  shared bus; driven only on an accepted read, else high-Z
//   RegWrt   in     1 = write, 0 = read
//   enReg    in     access enable
//   clr_req  in     request a bulk clear of all registers
//   busy     out    clear sequence in progress
//   err_addr out    sticky out-of-range access flag
// ============================================================================
module bus_register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  input  logic              RegWrt,
  input  logic              enReg,
  input  logic              clr_req,
  output logic              busy,
  output logic              err_addr
);

  // Storage is indexed with just enough bits for NUM_REGS entries. The upper
  // address bits only take part in the range check.
  localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned       NREGS_U  = NUM_REGS;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic              addr_ok;
  logic              zero_hit;
  logic              wr_en;
  logic              rd_en;
  logic [IDX_W-1:0]  addr_idx;
  logic [DATA_W-1:0] rd_data;

  assign busy     = (state_q == CLEAR);
  assign err_addr = err_q;

  assign addr_ok  = (32'(addr) < NREGS_U);
  assign zero_hit = (ZERO_REG != 0) && (addr == '0);
  assign addr_idx = addr[IDX_W-1:0];

  // While busy, the bus port is dead. There are no writes, no drive, and
  // no error updates.
  assign wr_en = enReg & RegWrt & ~busy & addr_ok & ~zero_hit;
  assign rd_en = enReg & ~RegWrt & ~busy;

  assign rd_data = (addr_ok && !zero_hit) ? regs_q[addr_idx] : '0;
  assign data    = rd_en ? rd_data : {DATA_W{1'bz}};

  // --------------------------------------------------------------------------
  // Control state: clear sequencer and sticky error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // An accepted clear takes priority over setting the error flag in
        // the same cycle, so the flag always starts clean after a clear.
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
          err_d   = 1'b0;
        end else if (enReg && !addr_ok) begin
          err_d = 1'b1;
        end
      end
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register array. One entry is zeroed per cycle while clearing. A bus write
  // can never coincide with clearing, because wr_en is gated by busy.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (busy && (idx_q == ADDR_W'(i))) begin
          regs_q[i] <= '0;
        end else if (wr_en && (addr_idx == IDX_W'(i))) begin
          regs_q[i] <= data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_register_file
// Purpose  : Directed self-checking bench for bus_register_file. It uses two
//            instances: A (32x32, hardwired zero) and B (16x16, ordinary
//            register 0). Undriven buses are pulled high, so the released
//            (high-Z) state reads as all ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_register_file;

  localparam int AW = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Instance A signals
  logic [AW-1:0] addr_a = '0;
  logic          wr_a = 1'b0, en_a = 1'b0, clr_a = 1'b0, drv_a = 1'b0;
  logic [31:0]   val_a = '0;
  wire           busy_a, err_a;
  tri1 [31:0]    data_a;
  assign data_a = drv_a ? val_a : 'z;

  // Instance B signals
  logic [AW-1:0] addr_b = '0;
  logic          wr_b = 1'b0, en_b = 1'b0, clr_b = 1'b0, drv_b = 1'b0;
  logic [15:0]   val_b = '0;
  wire           busy_b, err_b;
  tri1 [15:0]    data_b;
  assign data_b = drv_b ? val_b : 'z;

  bus_register_file #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(AW), .ZERO_REG(1)) u_dut_a (
    .clock(clock), .reset(reset), .addr(addr_a), .data(data_a),
    .RegWrt(wr_a), .enReg(en_a), .clr_req(clr_a), .busy(busy_a), .err_addr(err_a)
  );

  bus_register_file #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(AW), .ZERO_REG(0)) u_dut_b (
    .clock(clock), .reset(reset), .addr(addr_b), .data(data_b),
    .RegWrt(wr_b), .enReg(en_b), .clr_req(clr_b), .busy(busy_b), .err_addr(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bus_val(input bit b);
    return b ? {16'h0, data_b} : data_a;
  endfunction

  function automatic logic [31:0] hiz(input bit b);
    return b ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Sets the control inputs of one instance and releases the bench bus drive.
  task automatic set_ctl(input bit b, input bit en, input bit wr, input bit clr, input logic [AW-1:0] a);
    if (b) begin
      en_b = en; wr_b = wr; clr_b = clr; addr_b = a; drv_b = 1'b0;
    end else begin
      en_a = en; wr_a = wr; clr_a = clr; addr_a = a; drv_a = 1'b0;
    end
  endtask

  task automatic idle(input bit b);
    @(negedge clock);
    set_ctl(b, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clock); #1;
  endtask

  // Write: first confirms that the DUT does not drive the bus, then drives data.
  task automatic do_wr(input bit b, input logic [AW-1:0] a, input logic [31:0] v);
    @(negedge clock);
    set_ctl(b, 1'b1, 1'b1, 1'b0, a);
    #1 check(b ? "wr_hiz_b" : "wr_hiz_a", bus_val(b), hiz(b));
    if (b) begin val_b = v[15:0]; drv_b = 1'b1; end
    else   begin val_a = v;       drv_a = 1'b1; end
    @(posedge clock); #1;
  endtask

  task automatic do_rd(input bit b, input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clock);
    set_ctl(b, 1'b1, 1'b0, 1'b0, a);
    #1 check(tag, bus_val(b), exp);
    @(posedge clock); #1;
  endtask

  // Pulses clr_req for one cycle and counts how many cycles busy stays high.
  task automatic clear_len(input bit b, output int n);
    @(negedge clock);
    set_ctl(b, 1'b0, 1'b0, 1'b1, '0);
    @(posedge clock); #1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (!(b ? busy_b : busy_a)) break;
      n++;
      @(negedge clock);
      set_ctl(b, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;

    // ---------------- reset state ----------------
    #1;
    check("rst_busy_a", {31'h0, busy_a}, 32'h0);
    check("rst_err_a",  {31'h0, err_a},  32'h0);
    check("rst_hiz_a",  bus_val(1'b0), hiz(1'b0));
    check("rst_busy_b", {31'h0, busy_b}, 32'h0);
    @(posedge clock); @(posedge clock);
    @(negedge clock); reset = 1'b1;
    do_rd(1'b0, 6'd7, 32'h0, "rst_reg7_a");

    // ---------------- write i to addr i, read back ----------------
    for (int i = 0; i < 32; i++) do_wr(1'b0, AW'(i), 32'(i));
    for (int i = 0; i < 32; i++) do_rd(1'b0, AW'(i), 32'(i), "rd_seq_a");
    check("err_after_seq", {31'h0, err_a}, 32'h0);

    // ---------------- out-of-range access ----------------
    do_wr(1'b0, 6'd32, 32'hDEAD_BEEF);
    check("oor_err_set", {31'h0, err_a}, 32'h1);
    do_rd(1'b0, 6'd33, 32'h0, "oor_rd_zero");
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("oor_err_sticky", {31'h0, err_a}, 32'h1);
    end
    do_rd(1'b0, 6'd31, 32'd31, "oor_keep31");
    do_rd(1'b0, 6'd1,  32'd1,  "oor_keep1");

    // ---------------- bulk clear, with accesses during busy ----------------
    @(negedge clock);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, '0);
    @(posedge clock); #1;
    check("clr_busy_start", {31'h0, busy_a}, 32'h1);
    check("clr_err_clear",  {31'h0, err_a},  32'h0);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy_a) break;
      n++;
      @(negedge clock);
      set_ctl(1'b0, 1'b0, 1'b0, (n == 20), '0);
      if (n == 10) begin
        set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 6'd5);
        val_a = 32'h55; drv_a = 1'b1;
      end
      if (n == 12) begin
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 6'd3);
        #1 check("busy_rd_hiz", bus_val(1'b0), hiz(1'b0));
      end
      if (n == 15) set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 6'd40);
      @(posedge clock); #1;
    end
    check("clr_len_a", 32'(n), 32'd32);
    check("clr_err_busy_oor", {31'h0, err_a}, 32'h0);
    for (int i = 0; i < 32; i++) do_rd(1'b0, AW'(i), 32'h0, "rd_after_clr");

    // ---------------- disabled accesses ----------------
    for (int i = 1; i < 32; i++) do_wr(1'b0, AW'(i), 32'h100 + 32'(i));
    for (int a = 0; a <= 32; a++) begin
      @(negedge clock);
      set_ctl(1'b0, 1'b0, 1'b1, 1'b0, AW'(a));
      #1 check("dis_hiz", bus_val(1'b0), hiz(1'b0));
      val_a = 32'hA5A5_0000 | 32'(a); drv_a = 1'b1;
      @(posedge clock); #1;
    end
    check("dis_err", {31'h0, err_a}, 32'h0);
    for (int i = 0; i < 32; i++)
      do_rd(1'b0, AW'(i), (i == 0) ? 32'h0 : 32'h100 + 32'(i), "dis_keep");

    // ---------------- reset during clear ----------------
    @(negedge clock);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b1, '0);
    @(posedge clock); #1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy_a || n == 10) break;
      n++;
      @(negedge clock);
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clock); #1;
    end
    check("mid_busy_before", {31'h0, busy_a}, 32'h1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy_a}, 32'h0);
    check("mid_rst_err",  {31'h0, err_a},  32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) do_rd(1'b0, AW'(i), 32'h0, "rd_after_rst");
    do_wr(1'b0, 6'd7, 32'h77);
    do_rd(1'b0, 6'd7, 32'h77, "post_rst_wr7");
    do_wr(1'b0, 6'd0, 32'hCAFE);
    do_rd(1'b0, 6'd0, 32'h0, "zero_reg_a");
    idle(1'b0);

    // ---------------- instance B: 16x16, ordinary register 0 ----------------
    do_wr(1'b1, 6'd0, 32'h1234);
    do_rd(1'b1, 6'd0, 32'h1234, "b_reg0");
    do_wr(1'b1, 6'd15, 32'hBEEF);
    do_rd(1'b1, 6'd15, 32'hBEEF, "b_reg15");
    check("b_err_before", {31'h0, err_b}, 32'h0);
    do_rd(1'b1, 6'd16, 32'h0, "b_oor_rd");
    check("b_err_set", {31'h0, err_b}, 32'h1);
    clear_len(1'b1, n);
    check("clr_len_b", 32'(n), 32'd16);
    check("b_err_clr", {31'h0, err_b}, 32'h0);
    do_rd(1'b1, 6'd0,  32'h0, "b_reg0_clr");
    do_rd(1'b1, 6'd15, 32'h0, "b_reg15_clr");
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
